// File: rtl/toggle_arbiter.sv
// toggle_arbiter: four requesters share one toggle register `foo`.
// A round-robin FSM (IDLE -> GRANT -> COOL -> IDLE) grants one requester at
// a time; while the granted request stays high, foo inverts on each granted
// edge, up to MAX_HOLD times per grant. All outputs are registered.
// Optional macro TOGGLE_ARBITER_COUNT_EN adds an 8-bit wrapping count of
// foo toggles on port toggle_count.
module toggle_arbiter #(
   parameter int   NREQ     = 4,
   parameter int   MAX_HOLD = 3,
   parameter logic FOO_INIT = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant,
   output logic            busy,
   output logic            foo,
   output logic [1:0]      last_id
`ifdef TOGGLE_ARBITER_COUNT_EN
   ,
   output logic [7:0]      toggle_count
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GRANT = 2'b01,
      COOL  = 2'b10
   } state_t;

   state_t     state;
   logic [3:0] hold_cnt;

   // Candidate indices in round-robin order, starting just after last winner.
   logic [1:0] cand_idx [4];
   logic [3:0] cand_hit;
   logic [1:0] win_id;
   logic       hold_left;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_cand
         assign cand_idx[gi] = last_id + 2'(gi + 1);
         assign cand_hit[gi] = req[cand_idx[gi]];
      end
   endgenerate

   assign hold_left = (hold_cnt < 4'(MAX_HOLD));

   // Pick the first requesting candidate; lowest rotation offset wins.
   always_comb begin
      win_id = cand_idx[3];
      for (int k = 3; k >= 0; k--) begin
         if (cand_hit[k]) begin
            win_id = cand_idx[k];
         end
      end
   end

   // Arbitration FSM with registered grant/busy/foo/last_id outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         busy     <= 1'b0;
         foo      <= FOO_INIT;
         last_id  <= 2'd3;
         hold_cnt <= 4'd0;
`ifdef TOGGLE_ARBITER_COUNT_EN
         toggle_count <= 8'h00;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req == '0) begin
                  // nothing requested: every register holds
               end else begin
                  grant    <= {{(NREQ-1){1'b0}}, 1'b1} << win_id;
                  last_id  <= win_id;
                  hold_cnt <= 4'd0;
                  busy     <= 1'b1;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               // last_id holds the currently granted index while in GRANT
               case ({req[last_id], hold_left})
                  2'b11: begin
                     foo      <= ~foo;
                     hold_cnt <= hold_cnt + 4'd1;
`ifdef TOGGLE_ARBITER_COUNT_EN
                     toggle_count <= toggle_count + 8'd1;
`endif
                  end
                  2'b10: begin
                     grant <= '0;
                     state <= COOL;
                  end
                  default: begin
                     // request withdrawn: no toggle, release the grant
                     grant <= '0;
                     state <= COOL;
                  end
               endcase
            end
            COOL: begin
               // one dead cycle; requests are not looked at here
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               grant <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_toggle_arbiter.sv
// Testbench for toggle_arbiter: a behavioural reference model produces the
// expected outputs for every driven cycle, which are queued and compared
// against the DUT after the following clock edge.
module tb_toggle_arbiter;

   localparam int MAX_HOLD = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [3:0] grant;
   logic       busy;
   logic       foo;
   logic [1:0] last_id;
`ifdef TOGGLE_ARBITER_COUNT_EN
   logic [7:0] toggle_count;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [15:0] exp_q [$];

   // reference model state
   int         m_state;
   logic [3:0] m_grant;
   logic       m_busy;
   logic       m_foo;
   int         m_last;
   int         m_hold;
   logic [7:0] m_cnt;

   toggle_arbiter #(.NREQ(4), .MAX_HOLD(MAX_HOLD), .FOO_INIT(1'b0)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .grant   (grant),
      .busy    (busy),
      .foo     (foo),
      .last_id (last_id)
`ifdef TOGGLE_ARBITER_COUNT_EN
      ,
      .toggle_count (toggle_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] observed();
      logic [7:0] c;
`ifdef TOGGLE_ARBITER_COUNT_EN
      c = toggle_count;
`else
      c = 8'h00;
`endif
      return {c, grant, busy, foo, last_id};
   endfunction

   function automatic logic [15:0] model_outputs();
      logic [7:0] c;
`ifdef TOGGLE_ARBITER_COUNT_EN
      c = m_cnt;
`else
      c = 8'h00;
`endif
      return {c, m_grant, m_busy, m_foo, 2'(m_last)};
   endfunction

   task automatic model_step(input logic [3:0] r, input logic rs);
      int w;
      if (rs) begin
         m_state = 0; m_grant = 4'b0000; m_busy = 1'b0; m_foo = 1'b0;
         m_last = 3; m_hold = 0; m_cnt = 8'h00;
      end else if (m_state == 0) begin
         if (r != 4'b0000) begin
            w = -1;
            for (int off = 1; off <= 4; off++) begin
               if (w < 0 && r[(m_last + off) % 4]) w = (m_last + off) % 4;
            end
            m_grant = 4'b0001 << w;
            m_last  = w;
            m_hold  = 0;
            m_busy  = 1'b1;
            m_state = 1;
         end
      end else if (m_state == 1) begin
         if (r[m_last] && m_hold < MAX_HOLD) begin
            m_foo  = ~m_foo;
            m_hold = m_hold + 1;
            m_cnt  = m_cnt + 8'd1;
         end else begin
            m_grant = 4'b0000;
            m_state = 2;
         end
      end else begin
         m_busy  = 1'b0;
         m_state = 0;
      end
   endtask

   // Drive one cycle of stimulus, queue the model's expectation, advance.
   task automatic cycle(input logic [3:0] r, input logic rs);
      req = r;
      rst = rs;
      model_step(r, rs);
      exp_q.push_back(model_outputs());
      @(posedge clk);
      #1;
      cyc++;
      $display("cyc %0d req=%b rst=%b -> grant=%b busy=%b foo=%b last_id=%0d",
               cyc, r, rs, grant, busy, foo, last_id);
   endtask

   task automatic test_reset();
      logic [15:0] e, g;
      for (int i = 0; i < 2; i++) begin
         cycle(4'b0000, 1'b1);
         e = exp_q.pop_front(); g = observed(); checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL reset cyc=%0d got=%h expected=%h", cyc, g, e);
         end
      end
      checks++;
      if ({grant, busy, foo, last_id} !== 8'b0000_0_0_11) begin
         errors++;
         $display("FAIL reset_values got=%b expected=%b", {grant, busy, foo, last_id}, 8'b00000011);
      end
   endtask

   task automatic test_idle_hold();
      logic [15:0] e, g;
      for (int i = 0; i < 10; i++) begin
         cycle(4'b0000, 1'b0);
         e = exp_q.pop_front(); g = observed(); checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL idle_hold cyc=%0d got=%h expected=%h", cyc, g, e);
         end
      end
   endtask

   task automatic test_single_hold();
      logic [15:0] e, g;
      logic        prev_foo;
      int          flips = 0;
      prev_foo = foo;
      for (int k = 1; k <= 13; k++) begin
         cycle(4'b0001, 1'b0);
         e = exp_q.pop_front(); g = observed(); checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL single_hold cyc=%0d got=%h expected=%h", cyc, g, e);
         end
         if (foo !== prev_foo) flips++;
         prev_foo = foo;
         if (k == 1 || k == 6) begin
            checks++;
            if (k == 1 && grant !== 4'b0001) begin
               errors++;
               $display("FAIL single_first_grant got=%b expected=0001", grant);
            end
            if (k == 6 && foo !== 1'b1) begin
               errors++;
               $display("FAIL single_foo_before_regrant got=%b expected=1", foo);
            end
         end
      end
      checks++;
      if (flips != 6) begin
         errors++;
         $display("FAIL single_toggle_count got=%0d expected=6", flips);
      end
   endtask

   task automatic test_round_robin();
      logic [15:0] e, g;
      logic [3:0]  prev_grant;
      int          wins [$];
      int          want [5] = '{0, 1, 2, 3, 0};
      cycle(4'b0000, 1'b1);
      void'(exp_q.pop_front());
      prev_grant = 4'b0000;
      for (int i = 0; i < 30; i++) begin
         cycle(4'b1111, 1'b0);
         e = exp_q.pop_front(); g = observed(); checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL round_robin cyc=%0d got=%h expected=%h", cyc, g, e);
         end
         if (prev_grant == 4'b0000 && grant != 4'b0000) begin
            for (int b = 0; b < 4; b++) if (grant[b]) wins.push_back(b);
         end
         prev_grant = grant;
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (i >= wins.size()) begin
            errors++;
            $display("FAIL rr_order idx=%0d got=none expected=%0d", i, want[i]);
         end else if (wins[i] != want[i]) begin
            errors++;
            $display("FAIL rr_order idx=%0d got=%0d expected=%0d", i, wins[i], want[i]);
         end
      end
   endtask

   task automatic test_short_req();
      logic [15:0] e, g;
      logic [3:0]  seq [5] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0101};
      logic        start_foo;
      cycle(4'b0000, 1'b1);
      void'(exp_q.pop_front());
      start_foo = foo;
      for (int i = 0; i < 5; i++) begin
         cycle(seq[i], 1'b0);
         e = exp_q.pop_front(); g = observed(); checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL short_req cyc=%0d got=%h expected=%h", cyc, g, e);
         end
         if (i == 3) begin
            checks++;
            if (foo !== ~start_foo) begin
               errors++;
               $display("FAIL short_one_toggle got=%b expected=%b", foo, ~start_foo);
            end
         end
      end
      checks++;
      if (grant !== 4'b0001 || last_id !== 2'd0) begin
         errors++;
         $display("FAIL short_rr_wrap got grant=%b last_id=%0d expected grant=0001 last_id=0", grant, last_id);
      end
   endtask

   task automatic test_reset_mid_grant();
      logic [15:0] e, g;
      cycle(4'b0000, 1'b1);
      void'(exp_q.pop_front());
      cycle(4'b0001, 1'b0);
      void'(exp_q.pop_front());
      cycle(4'b0001, 1'b0);
      e = exp_q.pop_front(); g = observed(); checks++;
      if (g !== e || foo !== 1'b1) begin
         errors++;
         $display("FAIL mid_grant_pre got=%h expected=%h", g, e);
      end
      cycle(4'b0001, 1'b1);
      e = exp_q.pop_front(); g = observed(); checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL mid_grant_reset got=%h expected=%h", g, e);
      end
      checks++;
      if ({grant, busy, foo, last_id} !== 8'b0000_0_0_11) begin
         errors++;
         $display("FAIL mid_grant_values got=%b expected=00000011", {grant, busy, foo, last_id});
      end
   endtask

`ifdef TOGGLE_ARBITER_COUNT_EN
   task automatic test_toggle_count();
      logic [15:0] e, g;
      logic        prev_foo;
      int          flips = 0;
      cycle(4'b0000, 1'b1);
      void'(exp_q.pop_front());
      prev_foo = foo;
      for (int i = 0; i < 40; i++) begin
         cycle(4'b1111, 1'b0);
         e = exp_q.pop_front(); g = observed(); checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL count_run cyc=%0d got=%h expected=%h", cyc, g, e);
         end
         if (foo !== prev_foo) flips++;
         prev_foo = foo;
      end
      checks++;
      if (toggle_count !== 8'(flips)) begin
         errors++;
         $display("FAIL count_total got=%0d expected=%0d", toggle_count, flips);
      end
      // wrap check from a preloaded value
      cycle(4'b0000, 1'b1);
      void'(exp_q.pop_front());
      force dut.toggle_count = 8'hFE;
      #2;
      release dut.toggle_count;
      m_cnt = 8'hFE;
      for (int i = 0; i < 3; i++) begin
         cycle(4'b0001, 1'b0);
         void'(exp_q.pop_front());
      end
      checks++;
      if (toggle_count !== 8'h00) begin
         errors++;
         $display("FAIL count_wrap got=%h expected=00", toggle_count);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_idle_hold();
      test_single_hold();
      test_round_robin();
      test_short_req();
      test_reset_mid_grant();
`ifdef TOGGLE_ARBITER_COUNT_EN
      test_toggle_count();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
